// File: rtl/uart_pkg.sv
// Shared definitions for the host serial link: transmitter FSM states,
// the protocol bytes exchanged with the host, and the bit-time helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [7:0] LOAD_START_BYTE = 8'hAA;
    localparam logic [7:0] LOAD_ACK_BYTE   = 8'h55;

    // One serial bit lasts two half-bit periods.
    function automatic int BIT_CLKS(input int clk_per_half_bit);
        return 2 * clk_per_half_bit;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO for the transmit path: up to four entries pushed per cycle
// (a whole CPU word), one entry popped per cycle. Space checking is left
// to the caller; this block just stores and counts.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2:0]           push_n,
    input  logic [3:0][7:0]      push_data,
    input  logic                 pop,
    output logic [FIFO_AW:0]     count,
    output logic [7:0]           head
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;

    // Storage write: entry i of the push lands at wptr+i, wrapping naturally.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < push_n)
                mem[wptr + FIFO_AW'(i)] <= push_data[i];
        end
    end

    // Pointers and occupancy; a push and a pop in one cycle both take effect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + FIFO_AW'(push_n);
            rptr  <= rptr + FIFO_AW'(pop);
            count <= count + (FIFO_AW+1)'(push_n) - (FIFO_AW+1)'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/uart_out_sender.sv
// Transmit side of the host serial link. CPU byte/word writes and the
// load acknowledge are queued in a byte FIFO and sent as 8N1 frames,
// LSB first, back to back while data is waiting.
module uart_out_sender
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int FIFO_AW          = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_byte,
    input  logic               wr_word,
    input  logic [31:0]        wr_data,
    input  logic               send_ack,
    output logic               txd,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               ovf
);

    localparam int             BIT_N    = BIT_CLKS(CLK_PER_HALF_BIT);
    localparam int             CW       = $clog2(BIT_N);
    localparam int             DEPTH    = 1 << FIFO_AW;
    localparam logic [CW-1:0]  BAUD_MAX = CW'(BIT_N - 1);

    tx_state_t          state, state_n;
    logic [CW-1:0]      baud_cnt;
    logic [2:0]         bitidx;
    logic [7:0]         shreg, shreg_n;
    logic               period_end;
    logic               pop;
    logic               txd_d;

    logic [FIFO_AW:0]   free;
    logic [2:0]         push_n;
    logic [3:0][7:0]    push_data;
    logic               push_drop;
    logic [7:0]         head;

    // Free space is judged on the pre-pop count, so a same-cycle pop never
    // makes room for a push.
    assign free = (FIFO_AW+1)'(DEPTH) - fifo_cnt;

    // Push arbitration: ack beats word beats byte; losers are simply ignored.
    always_comb begin
        push_n    = '0;
        push_data = '0;
        push_drop = 1'b0;
        if (send_ack) begin
            if (free >= (FIFO_AW+1)'(1)) begin
                push_n       = 3'd1;
                push_data[0] = LOAD_ACK_BYTE;
            end else begin
                push_drop = 1'b1;
            end
        end else if (wr_word) begin
            if (free >= (FIFO_AW+1)'(4)) begin
                push_n       = 3'd4;
                push_data[0] = wr_data[31:24];
                push_data[1] = wr_data[23:16];
                push_data[2] = wr_data[15:8];
                push_data[3] = wr_data[7:0];
            end else begin
                push_drop = 1'b1;
            end
        end else if (wr_byte) begin
            if (free >= (FIFO_AW+1)'(1)) begin
                push_n       = 3'd1;
                push_data[0] = wr_data[7:0];
            end else begin
                push_drop = 1'b1;
            end
        end
    end

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_n    (push_n),
        .push_data (push_data),
        .pop       (pop),
        .count     (fifo_cnt),
        .head      (head)
    );

    // Dropped pushes are remembered until reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          ovf <= 1'b0;
        else if (push_drop) ovf <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    assign period_end = (baud_cnt == BAUD_MAX);

    // Next state, pop decision and next shift-register contents.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (period_end) state_n = DATA;
            end
            DATA: begin
                if (period_end && bitidx == 3'd7) state_n = STOP;
            end
            STOP: begin
                if (period_end) begin
                    if (fifo_cnt != '0) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (pop)                            shreg_n = head;
        else if (state == DATA && period_end) shreg_n = {1'b0, shreg[7:1]};
        else                                shreg_n = shreg;
    end

    // Baud counter, bit index and shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            baud_cnt <= '0;
            bitidx   <= '0;
            shreg    <= '0;
        end else begin
            shreg <= shreg_n;
            if (pop) begin
                baud_cnt <= '0;
                bitidx   <= '0;
            end else begin
                if (state != IDLE)
                    baud_cnt <= period_end ? '0 : baud_cnt + 1'b1;
                if (state == DATA && period_end)
                    bitidx <= bitidx + 1'b1;
            end
        end
    end

    // Line level for the coming cycle is derived from where the FSM is headed,
    // which lets txd be a plain register with no extra cycle of latency.
    always_comb begin
        case (state_n)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_n[0];
            default: txd_d = 1'b1;
        endcase
        tx_busy = (state != IDLE) || (fifo_cnt != '0);
    end

    // Registered serial output; reset drives the line idle immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) txd <= 1'b1;
        else       txd <= txd_d;
    end

endmodule

// File: tb/tb_uart_out_sender.sv
// Bench for uart_out_sender: a cycle model (queue + frame time left) checks
// line level, count, busy and overflow every cycle; a separate monitor
// decodes frames off txd and matches them against a scoreboard queue.
module tb_uart_out_sender;

    localparam int HB    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int BITC  = 2 * HB;
    localparam int FRAME = 10 * BITC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_byte = 1'b0;
    logic        wr_word = 1'b0;
    logic        send_ack = 1'b0;
    logic [31:0] wr_data = '0;
    logic        txd;
    logic        tx_busy;
    logic [AW:0] fifo_cnt;
    logic        ovf;

    always #5 clk = ~clk;

    uart_out_sender #(.CLK_PER_HALF_BIT(HB), .FIFO_AW(AW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_byte  (wr_byte),
        .wr_word  (wr_word),
        .wr_data  (wr_data),
        .send_ack (send_ack),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf)
    );

    int vecs = 0;
    int errs = 0;

    // Reference model state.
    logic [7:0] mq[$];      // bytes waiting in the FIFO
    logic [7:0] exp_q[$];   // scoreboard: every accepted byte, in send order
    int         m_left = 0; // clocks remaining in the frame on the line
    bit         m_ovf  = 0;
    logic [7:0] cur    = '0;
    int         rst_gen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_txd();
        int idx;
        if (m_left == 0) return 1'b1;
        idx = (FRAME - m_left) / BITC;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return cur[idx-1];
    endfunction

    // Drive one cycle of strobes, advance the model across the edge, check at the next negedge.
    task automatic cyc(input bit a, input bit w, input bit b, input logic [31:0] d);
        bit         pop;
        int         free;
        logic [7:0] pb[$];
        send_ack = a; wr_word = w; wr_byte = b; wr_data = d;
        pop  = (m_left <= 1) && (mq.size() > 0);
        free = DEPTH - mq.size();
        if (a) begin
            if (free >= 1) pb.push_back(8'h55); else m_ovf = 1;
        end else if (w) begin
            if (free >= 4) begin
                pb.push_back(d[31:24]); pb.push_back(d[23:16]);
                pb.push_back(d[15:8]);  pb.push_back(d[7:0]);
            end else m_ovf = 1;
        end else if (b) begin
            if (free >= 1) pb.push_back(d[7:0]); else m_ovf = 1;
        end
        if (pop) begin
            cur    = mq.pop_front();
            m_left = FRAME;
        end else if (m_left > 0) begin
            m_left--;
        end
        foreach (pb[i]) begin
            mq.push_back(pb[i]);
            exp_q.push_back(pb[i]);
        end
        @(posedge clk);
        @(negedge clk);
        chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("tx_busy", 32'(tx_busy), 32'((m_left > 0) || (mq.size() > 0)));
        chk("txd", 32'(txd), 32'(m_txd()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0);
    endtask

    task automatic drain();
        int k = 0;
        while ((mq.size() > 0 || m_left > 0) && k < 3000) begin
            cyc(0, 0, 0, 32'h0);
            k++;
        end
        chk("drain_timeout", 32'(k < 3000), 32'd1);
        idle(12);
    endtask

    // Frame monitor: samples mid-bit, pops the scoreboard per completed frame.
    initial begin
        int         g;
        logic       s, p;
        logic [7:0] dbyte;
        logic [7:0] e;
        forever begin
            @(negedge txd);
            if (!rstn) continue;
            g = rst_gen;
            repeat (4) @(negedge clk);
            s = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (BITC) @(negedge clk);
                dbyte[i] = txd;
            end
            repeat (BITC) @(negedge clk);
            p = txd;
            if (g != rst_gen || !rstn) continue;
            chk("start_bit", 32'(s), 32'd0);
            chk("stop_bit", 32'(p), 32'd1);
            if (exp_q.size() == 0) begin
                vecs++; errs++;
                $display("FAIL frame_unexpected: got %0h expected none", dbyte);
            end else begin
                e = exp_q.pop_front();
                chk("frame_byte", 32'(dbyte), 32'(e));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rstn = 1'b1;
        idle(3);

        // Single byte 0xA5
        cyc(0, 0, 1, 32'h0000_00A5);
        drain();

        // Word: four contiguous frames 12,34,56,78
        cyc(0, 1, 0, 32'h1234_5678);
        drain();

        // Fill to 6, word dropped, then a byte still fits
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 32'(8'h30 + i));
        cyc(0, 1, 0, 32'hDEAD_BEEF);
        cyc(0, 0, 1, 32'h0000_0040);
        drain();

        // Reset clears sticky ovf; then all three strobes at once -> only 0x55
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("ovf_rst", 32'(ovf), 32'd0);
        rst_gen++; mq.delete(); exp_q.delete(); m_left = 0; m_ovf = 0;
        @(negedge clk);
        rstn = 1'b1;
        idle(100);
        cyc(1, 1, 1, 32'hCAFE_F00D);
        drain();

        // Fill to full and keep pushing across pops; pointers wrap
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 32'(8'h80 + i));
        drain();

        // Reset in the middle of the data bits
        cyc(0, 0, 1, 32'h0000_00C3);
        idle(30);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        rst_gen++; mq.delete(); exp_q.delete(); m_left = 0; m_ovf = 0;
        @(negedge clk);
        rstn = 1'b1;
        idle(100);
        cyc(0, 0, 1, 32'h0000_0000);
        drain();

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            int unsigned r;
            r = $urandom_range(0, 15);
            case (r)
                0:       cyc(1, 0, 0, $urandom);
                1:       cyc(0, 1, 0, $urandom);
                2, 3:    cyc(0, 0, 1, $urandom);
                4:       cyc(0, 1, 1, $urandom);
                5:       cyc(1, 0, 1, $urandom);
                default: cyc(0, 0, 0, $urandom);
            endcase
        end
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
